core_sequencer: RTL

Multi-cycle control FSM for the 16-bit processor core. It sequences fetch, decode, execute and writeback over the existing instruction memory, register file, ALU and program counter. It generates one-cycle enables for the IR, PC and register-file write port, and handles fetch wait-states, illegal opcodes, and a debug halt/single-step interface. It replaces the single-cycle implicit control and sits beside the datapath, driven by the decoded opcode.

---
 rtl/core_pkg.sv | 24 ++
 rtl/fetch_watchdog.sv | 18 +
 rtl/core_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared opcode, pc_sel, fault and state encodings for the core sequencer
package core_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JALR = 3'b100;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;
  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_JALR;
  endfunction
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts FETCH cycles without ack; timeout on the LIMIT-th such cycle
// ports: clk, reset (async active-low), active (in FETCH), ack (imem_ack), timeout
module fetch_watchdog #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (active && !ack) ? cnt + 8'd1 : '0;
  // fires in the cycle the count reaches LIMIT, so the FSM leaves after exactly LIMIT waits
  assign timeout = active && !ack && (cnt + 8'd1 == LIMIT[7:0]);
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/writeback control FSM with debug halt
// ports: clk, reset (async active-low), opcode/jalr_link/branch_taken/imem_ack/halt_req/step in;
//        imem_req, ir_load, pc_load, pc_sel, reg_we, wb_sel, halted, trap, fault_code,
//        retired, retire_count out
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  opcode,
  input  logic        jalr_link,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        halt_req,
  input  logic        step,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  fault_code,
  output logic        retired,
  output logic [15:0] retire_count
);
  logic [2:0] state, next;
  logic timeout, beq_ex, wb, jalr;
  fetch_watchdog #(.LIMIT(FETCH_TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .active(imem_req), .ack(imem_ack), .timeout(timeout)
  );
  assign imem_req = state == S_FETCH;
  assign ir_load  = imem_req && imem_ack;
  assign beq_ex   = state == S_EXECUTE && opcode == OP_BEQ;
  assign wb       = state == S_WRITEBACK;
  assign jalr     = opcode == OP_JALR;
  assign retired  = beq_ex || wb;
  assign pc_load  = retired;
  assign pc_sel   = beq_ex ? (branch_taken ? PC_BR : PC_INC) : (wb && jalr) ? PC_REG : PC_INC;
  assign reg_we   = wb && (!jalr || jalr_link);
  assign wb_sel   = wb && jalr;
  assign halted   = state == S_HALT;
  assign trap     = state == S_TRAP;
  always_comb begin
    next = S_TRAP;
    case (state)
      S_IDLE:      next = halt_req ? S_HALT : S_FETCH;
      S_FETCH:     next = imem_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE:    next = is_legal(opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   next = S_WRITEBACK;
      S_HALT:      next = (step || !halt_req) ? S_FETCH : S_HALT;
      default:     next = S_TRAP;
    endcase
    // halt requests are only honoured once the instruction has retired
    if (retired) next = halt_req ? S_HALT : S_FETCH;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= S_IDLE;
      fault_code   <= FAULT_NONE;
      retire_count <= '0;
    end else begin
      state <= next;
      if (timeout) fault_code <= FAULT_TIMEOUT;
      else if (state == S_DECODE && !is_legal(opcode)) fault_code <= FAULT_ILLEGAL;
      if (retired) retire_count <= retire_count + 16'd1;
    end
endmodule
